// File: rtl/alu_mdu_param.sv
// Parameterised ALU with an iterative multiply/divide unit behind a valid/ready handshake.
// Single-cycle ops finish in one cycle; MUL/DIV take WIDTH+1 cycles (shift-add / restoring).
module alu_mdu_param #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_NOR  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_SLL  = 5'd10, OP_SRL  = 5'd11;
    localparam logic [4:0] OP_SRA  = 5'd12, OP_LUI  = 5'd13, OP_MUL  = 5'd14, OP_MULU = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16, OP_DIVU = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic              zero_q, zero_d, carry_q, carry_d, negative_q, negative_d;
    logic              overflow_q, overflow_d, div_by_zero_q, div_by_zero_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d, quo_q, quo_d, mag_q, mag_d, orig_a_q, orig_a_d;
    logic              sgn_q, sgn_d, rsgn_q, rsgn_d, dz_q, dz_d, ov_q, ov_d;

    // Single-cycle ALU, evaluated on the live operands at acceptance.
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, sra_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    assign sh    = a[SHW-1:0];
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};
    // An extra bit past the end of b catches the last bit shifted out.
    assign shl_w = {1'b0, b} << sh;
    assign shr_w = {b, 1'b0} >> sh;
    assign sra_w = $signed({b, 1'b0}) >>> sh;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SRL: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            OP_SRA: begin
                alu_res = sra_w[WIDTH:1];
                alu_c   = sra_w[0];
            end
            OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: ;
        endcase
    end

    // MDU works on magnitudes; signs are reapplied on the final cycle.
    logic             is_mul, is_div, mdu_signed, a_neg, b_neg, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mul     = (op == OP_MUL) || (op == OP_MULU);
    assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign mdu_signed = (op == OP_MUL) || (op == OP_DIV);
    assign a_neg      = mdu_signed && a[WIDTH-1];
    assign b_neg      = mdu_signed && b[WIDTH-1];
    assign a_mag      = a_neg ? -a : a;
    assign b_mag      = b_neg ? -b : b;
    assign div_ovf    = (op == OP_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    logic [WIDTH:0]     mul_sum, div_r, div_t;
    logic [WIDTH-1:0]   mul_acc_n, mul_quo_n, div_acc_n, div_quo_n, quot, rem;
    logic [2*WIDTH-1:0] prod, prod_f;

    assign mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, mag_q} : '0);
    assign mul_acc_n = mul_sum[WIDTH:1];
    assign mul_quo_n = {mul_sum[0], quo_q[WIDTH-1:1]};
    assign prod      = {mul_acc_n, mul_quo_n};
    assign prod_f    = sgn_q ? -prod : prod;

    // Restoring step: a borrow out of the trial subtraction keeps the old partial remainder.
    assign div_r     = {acc_q, quo_q[WIDTH-1]};
    assign div_t     = div_r - {1'b0, mag_q};
    assign div_acc_n = div_t[WIDTH] ? div_r[WIDTH-1:0] : div_t[WIDTH-1:0];
    assign div_quo_n = {quo_q[WIDTH-2:0], ~div_t[WIDTH]};
    assign quot      = dz_q ? '1       : (sgn_q  ? -div_quo_n : div_quo_n);
    assign rem       = dz_q ? orig_a_q : (rsgn_q ? -div_acc_n : div_acc_n);

    always_comb begin
        state_d       = state_q;
        res_lo_d      = res_lo_q;
        res_hi_d      = res_hi_q;
        zero_d        = zero_q;
        carry_d       = carry_q;
        negative_d    = negative_q;
        overflow_d    = overflow_q;
        div_by_zero_d = div_by_zero_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        quo_d         = quo_q;
        mag_d         = mag_q;
        orig_a_d      = orig_a_q;
        sgn_d         = sgn_q;
        rsgn_d        = rsgn_q;
        dz_d          = dz_q;
        ov_d          = ov_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    cnt_d    = '0;
                    acc_d    = '0;
                    sgn_d    = a_neg ^ b_neg;
                    rsgn_d   = a_neg;
                    dz_d     = (b == '0);
                    ov_d     = div_ovf;
                    orig_a_d = a;
                    if (is_mul) begin
                        state_d = S_MUL;
                        quo_d   = b_mag;
                        mag_d   = a_mag;
                    end else if (is_div) begin
                        state_d = S_DIV;
                        quo_d   = a_mag;
                        mag_d   = b_mag;
                    end else begin
                        state_d       = S_DONE;
                        res_lo_d      = alu_res;
                        res_hi_d      = '0;
                        zero_d        = (alu_res == '0);
                        carry_d       = alu_c;
                        negative_d    = alu_res[WIDTH-1];
                        overflow_d    = alu_v;
                        div_by_zero_d = 1'b0;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc_n;
                quo_d = mul_quo_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d       = S_DONE;
                    {res_hi_d, res_lo_d} = prod_f;
                    zero_d        = (prod_f == '0);
                    carry_d       = 1'b0;
                    negative_d    = prod_f[2*WIDTH-1];
                    overflow_d    = 1'b0;
                    div_by_zero_d = 1'b0;
                end
            end
            S_DIV: begin
                acc_d = div_acc_n;
                quo_d = div_quo_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d       = S_DONE;
                    res_lo_d      = quot;
                    res_hi_d      = rem;
                    zero_d        = (quot == '0);
                    carry_d       = 1'b0;
                    negative_d    = quot[WIDTH-1];
                    overflow_d    = ov_q;
                    div_by_zero_d = dz_q;
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            res_lo_q      <= '0;
            res_hi_q      <= '0;
            zero_q        <= 1'b0;
            carry_q       <= 1'b0;
            negative_q    <= 1'b0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            cnt_q         <= '0;
            acc_q         <= '0;
            quo_q         <= '0;
            mag_q         <= '0;
            orig_a_q      <= '0;
            sgn_q         <= 1'b0;
            rsgn_q        <= 1'b0;
            dz_q          <= 1'b0;
            ov_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            res_lo_q      <= res_lo_d;
            res_hi_q      <= res_hi_d;
            zero_q        <= zero_d;
            carry_q       <= carry_d;
            negative_q    <= negative_d;
            overflow_q    <= overflow_d;
            div_by_zero_q <= div_by_zero_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            quo_q         <= quo_d;
            mag_q         <= mag_d;
            orig_a_q      <= orig_a_d;
            sgn_q         <= sgn_d;
            rsgn_q        <= rsgn_d;
            dz_q          <= dz_d;
            ov_q          <= ov_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign negative    = negative_q;
    assign overflow    = overflow_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_alu_mdu_param.sv
// Directed bench for alu_mdu_param at WIDTH=32: hand-computed vectors checked with immediate assertions.
module tb_alu_mdu_param;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op = 5'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result_lo, result_hi;
    logic         zero, carry, negative, overflow, div_by_zero;

    int checks = 0;
    int errors = 0;
    bit ready_seen;

    always #5 clk = ~clk;

    alu_mdu_param #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result_lo(result_lo), .result_hi(result_hi), .zero(zero), .carry(carry),
        .negative(negative), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected flags packed as {zero, carry, negative, overflow, div_by_zero}.
    task automatic check_flags(input string tag, input logic [4:0] exp);
        check({tag, " flags"}, {59'd0, zero, carry, negative, overflow, div_by_zero}, {59'd0, exp});
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo,
                             input logic [4:0] flags);
        check({tag, " result"}, {result_hi, result_lo}, {hi, lo});
        check_flags(tag, flags);
    endtask

    // Issue one request, scramble the inputs after acceptance, wait for out_valid.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int exp_lat);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 5'd31; a = $urandom; b = $urandom;
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            ready_seen |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        bit valid_seen;

        // Reset state
        #2;
        check("reset in_ready", {63'd0, in_ready}, 64'd0);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check_res("reset", '0, '0, 5'b00000);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", {63'd0, in_ready}, 64'd1);

        run_op("ADD ovf", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1);
        check_res("ADD ovf", '0, 32'h8000_0000, 5'b00110);
        ack("ADD ovf");

        run_op("ADDU carry", 5'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        check_res("ADDU carry", '0, 32'h0000_0000, 5'b11000);
        ack("ADDU carry");

        run_op("SUB borrow", 5'd2, 32'd5, 32'd7, 1);
        check_res("SUB borrow", '0, 32'hFFFF_FFFE, 5'b01100);
        ack("SUB borrow");

        run_op("SUB ovf", 5'd2, 32'h8000_0000, 32'd1, 1);
        check_res("SUB ovf", '0, 32'h7FFF_FFFF, 5'b00010);
        ack("SUB ovf");

        run_op("AND", 5'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
        check_res("AND", '0, 32'h00F0_1200, 5'b00000);
        ack("AND");
        run_op("OR", 5'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
        check_res("OR", '0, 32'hFFF0_FF34, 5'b00100);
        ack("OR");
        run_op("XOR", 5'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
        check_res("XOR", '0, 32'hFF00_ED34, 5'b00100);
        ack("XOR");
        run_op("NOR", 5'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
        check_res("NOR", '0, 32'h000F_00CB, 5'b00000);
        ack("NOR");

        run_op("SLT", 5'd8, 32'hFFFF_FFFF, 32'd1, 1);
        check_res("SLT", '0, 32'd1, 5'b00000);
        ack("SLT");
        run_op("SLTU", 5'd9, 32'hFFFF_FFFF, 32'd1, 1);
        check_res("SLTU", '0, 32'd0, 5'b10000);
        ack("SLTU");

        run_op("SLL carry", 5'd10, 32'd1, 32'h8000_0001, 1);
        check_res("SLL carry", '0, 32'h0000_0002, 5'b01000);
        ack("SLL carry");
        run_op("SLL amt0", 5'd10, 32'd32, 32'h0000_1234, 1);
        check_res("SLL amt0", '0, 32'h0000_1234, 5'b00000);
        ack("SLL amt0");
        run_op("SRA", 5'd12, 32'd4, 32'h8000_0010, 1);
        check_res("SRA", '0, 32'hF800_0001, 5'b00100);
        ack("SRA");
        run_op("SRL carry", 5'd11, 32'd4, 32'h0000_0018, 1);
        check_res("SRL carry", '0, 32'h0000_0001, 5'b01000);
        ack("SRL carry");
        run_op("LUI", 5'd13, 32'h0, 32'hABCD_1234, 1);
        check_res("LUI", '0, 32'h1234_0000, 5'b00000);
        ack("LUI");

        run_op("UNDEF", 5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        check_res("UNDEF", '0, '0, 5'b10000);
        ack("UNDEF");

        run_op("MUL", 5'd14, 32'hFFFF_FFFD, 32'd7, W + 1);
        check("MUL in_ready low", {63'd0, ready_seen}, 64'd0);
        check_res("MUL", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5'b00100);
        ack("MUL");

        run_op("MULU max", 5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1);
        check_res("MULU max", 32'hFFFF_FFFE, 32'h0000_0001, 5'b00100);
        ack("MULU max");

        run_op("MULU hi only", 5'd15, 32'h0001_0000, 32'h0001_0000, W + 1);
        check_res("MULU hi only", 32'h0000_0001, 32'h0000_0000, 5'b00000);
        ack("MULU hi only");

        run_op("DIV neg", 5'd16, 32'hFFFF_FFF9, 32'd2, W + 1);
        check_res("DIV neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5'b00100);
        ack("DIV neg");

        run_op("DIVU by0", 5'd17, 32'h1234_5678, 32'd0, W + 1);
        check_res("DIVU by0", 32'h1234_5678, 32'hFFFF_FFFF, 5'b00101);
        ack("DIVU by0");

        run_op("DIV min", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, W + 1);
        check_res("DIV min", 32'h0000_0000, 32'h8000_0000, 5'b00110);
        ack("DIV min");

        run_op("DIVU", 5'd17, 32'd100, 32'd7, W + 1);
        check_res("DIVU", 32'd2, 32'd14, 5'b00000);
        ack("DIVU");

        // Back-pressure: held result, competing request refused
        run_op("BP ADD", 5'd0, 32'd1, 32'd2, 1);
        in_valid = 1'b1; op = 5'd2; a = 32'd100; b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("BP out_valid", {63'd0, out_valid}, 64'd1);
            check("BP in_ready", {63'd0, in_ready}, 64'd0);
            check_res("BP hold", '0, 32'd3, 5'b00000);
        end
        in_valid = 1'b0;
        ack("BP");
        @(posedge clk); #1;
        check("BP nothing accepted", {63'd0, out_valid}, 64'd0);
        check("BP retained", {32'd0, result_lo}, 64'd3);

        // Reset in the middle of a DIV
        in_valid = 1'b1; op = 5'd17; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("RST in_ready", {63'd0, in_ready}, 64'd0);
        check("RST out_valid", {63'd0, out_valid}, 64'd0);
        check_res("RST outputs", '0, '0, 5'b00000);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("RST in_ready after", {63'd0, in_ready}, 64'd1);
        valid_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            valid_seen |= out_valid;
        end
        check("RST no output", {63'd0, valid_seen}, 64'd0);
        run_op("ADD after rst", 5'd0, 32'd2, 32'd3, 1);
        check_res("ADD after rst", '0, 32'd5, 5'b00000);
        ack("ADD after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu_param.md
ALU_MDU_PARAM -- requirements
Module: alu_mdu_param

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values are even and >= 8.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  5  opcode, defined in REQ-012.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid / out_ready  output / input  1 each  result handshake.
REQ-010 result_lo, result_hi  output  WIDTH each  result; result_hi is 0 for non-MDU ops.
REQ-011 zero, carry, negative, overflow, div_by_zero  output  1 each  status flags.

Function
REQ-012 Opcodes 0-13: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI. Opcodes 14-17: MUL, MULU, DIV, DIVU. Opcodes 18-31 are undefined.
REQ-013 A request is accepted only on a cycle where in_valid && in_ready; operands and op are captured at acceptance and ignored afterwards.
REQ-014 FSM states: IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE transitions on accept:
- opcodes 0-13 and undefined opcodes go to DONE.
- MUL/MULU go to MUL.
- DIV/DIVU go to DIV.
REQ-016 Latency from accept to out_valid:
- single-cycle ops: 1 cycle.
- MUL and DIV: WIDTH+1 cycles (one iteration per cycle, shift-add and restoring algorithms respectively).
REQ-017 DONE behaviour:
- out_valid=1.
- results and flags are held stable until out_ready=1.
- then transition to IDLE.
- out_ready is ignored outside DONE.
REQ-018 Shifts shift b by a[SHW-1:0]. LUI = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-019 SLT/SLTU give result_lo = 1 or 0, with a signed or unsigned compare respectively.
REQ-020 MUL/MULU give {result_hi,result_lo} = 2*WIDTH-bit signed or unsigned product.
REQ-021 DIV/DIVU give result_lo=quotient and result_hi=remainder. Signed quotient truncates toward zero; the remainder takes the sign of a.
REQ-022 Divide by zero (b==0): quotient all ones, remainder=a, div_by_zero=1, latency unchanged.
REQ-023 DIV with a=MIN and b=-1: quotient=MIN, remainder=0, overflow=1.
REQ-024 carry:
- ADD/ADDU: carry-out of bit WIDTH-1.
- SUB/SUBU: borrow (a<b unsigned).
- Shifts: last bit shifted out; 0 when the shift amount is 0.
- All other ops: 0.
REQ-025 overflow = signed overflow for ADD/SUB; 0 for all other ops except REQ-023.
REQ-026 zero=1 when result_lo==0. For MUL/MULU, zero=1 only when {result_hi,result_lo}==0.
REQ-027 negative = MSB of result_lo; for MUL/MULU it is the MSB of result_hi.
REQ-028 Undefined opcode: results 0, zero=1, all other flags 0.
REQ-029 Outputs retain their last values after DONE until the next result is loaded.

Reset
REQ-030 rst_n low forces, asynchronously: state=IDLE, in_ready=0 while reset is asserted, out_valid=0, result_lo=result_hi=0, all flags 0.
REQ-031 Reset mid-MUL, mid-DIV or in DONE aborts the operation with no output produced. in_ready=1 on the first clock edge after rst_n rises.

Verification
REQ-032 ADD with a=0x7FFFFFFF, b=1 -> after 1 cycle: result_lo=0x80000000, overflow=1, negative=1, carry=0.
REQ-033 MUL with a=-3, b=7 -> after 33 cycles: {hi,lo}=0xFFFFFFFF_FFFFFFEB, in_ready=0 throughout the operation.
REQ-034 DIV with a=-7, b=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU with b=0 -> lo=0xFFFFFFFF, hi=a, div_by_zero=1.
REQ-035 SRA with b=0x80000010, a=4 -> result_lo=0xF8000001, carry=0. SLL with a=32 -> amount 0, result=b, carry=0.
REQ-036 out_ready held low for 5 cycles -> out_valid and the outputs stay stable, and a new in_valid is not accepted.
REQ-037 rst_n pulsed low during cycle 10 of a DIV -> outputs zero immediately, no out_valid, next ADD completes normally.
